// File: rtl/matrix_vector_multiplier_lanes.sv
// ----------------------------------------------------------------------------
// matrix_vector_multiplier_lanes
//
// Computes c = A*b for a signed N x N matrix A and an N-vector b using LANES
// parallel MAC lanes. Each lane owns one output row per pass (group). A pass
// takes N MAC cycles and one write-back cycle, so a job completes
// GROUPS*(N+1) edges after the accept edge.
//
// Ports:
//   clk       clock, all state changes on its rising edge
//   rst       asynchronous active-high reset
//   ena       start request, accepted only while in_ready=1
//   in_ready  idle and able to accept a job
//   sat_mode  sampled with ena: 1 = saturate, 0 = wrap
//   matrix_a  N*N signed WIDTH-bit elements, a_ij MSB-first (row-major)
//   vector_b  N signed WIDTH-bit elements, b_j MSB-first
//   vector_c  N signed OUT_W-bit results, c_i MSB-first
//   done      one-cycle completion pulse
//   busy      job in progress (always ~in_ready)
//   overflow  at least one c_i of the last job fell outside the OUT_W range
// ----------------------------------------------------------------------------
module matrix_vector_multiplier_lanes #(
   parameter int N     = 3,
   parameter int WIDTH = 8,
   parameter int LANES = 1,
   parameter int OUT_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ena,
   output logic                     in_ready,
   input  logic                     sat_mode,
   input  logic [N*N*WIDTH-1:0]     matrix_a,
   input  logic [N*WIDTH-1:0]       vector_b,
   output logic [N*OUT_W-1:0]       vector_c,
   output logic                     done,
   output logic                     busy,
   output logic                     overflow
);

   localparam int CLOG_N = (N > 1) ? $clog2(N) : 0;
   localparam int ACC_W  = (2*WIDTH + CLOG_N > 2*WIDTH + 1) ? 2*WIDTH + CLOG_N : 2*WIDTH + 1;
   localparam int PROD_W = 2*WIDTH;
   localparam int GROUPS = (N + LANES - 1) / LANES;
   localparam int COL_W  = (N > 1) ? $clog2(N) : 1;
   localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(N-1);
   localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS-1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t                      state_r;
   logic [GRP_W-1:0]            grp_r;
   logic [COL_W-1:0]            col_r;
   logic [N*N*WIDTH-1:0]        mat_r;
   logic [N*WIDTH-1:0]          vec_r;
   logic                        sat_r;
   logic signed [ACC_W-1:0]     acc_r [LANES];
   logic [N*OUT_W-1:0]          res_r;
   logic                        ovf_job_r;

   logic signed [PROD_W-1:0]    prod_s [LANES];
   logic [LANES-1:0]            lane_act_s;
   logic [LANES-1:0]            lane_ovf_s;
   logic [N*OUT_W-1:0]          res_next_s;

   // Per-lane product for the current column, plus range check and conversion
   // of each finished accumulator merged into the next result buffer image.
   always_comb begin
      int                       row_v;
      int                       sel_v;
      logic signed [WIDTH-1:0]  a_v;
      logic signed [WIDTH-1:0]  b_v;
      logic [ACC_W-OUT_W:0]     hi_v;
      logic [OUT_W-1:0]         conv_v;
      row_v      = 0;
      sel_v      = 0;
      a_v        = '0;
      hi_v       = '0;
      conv_v     = '0;
      res_next_s = res_r;
      lane_act_s = '0;
      lane_ovf_s = '0;
      b_v        = $signed(vec_r[(N-1-int'(col_r))*WIDTH +: WIDTH]);
      for (int l = 0; l < LANES; l++) begin
         row_v = int'(grp_r) * LANES + l;
         // Lanes past the last row read row 0 harmlessly and are masked off.
         if (row_v < N) begin
            lane_act_s[l] = 1'b1;
            sel_v         = row_v;
         end else begin
            lane_act_s[l] = 1'b0;
            sel_v         = 0;
         end
         a_v       = $signed(mat_r[(N*N-1-(sel_v*N+int'(col_r)))*WIDTH +: WIDTH]);
         prod_s[l] = PROD_W'(a_v) * PROD_W'(b_v);
         // The value fits OUT_W bits exactly when all bits from OUT_W-1 up
         // to the accumulator MSB agree.
         hi_v          = acc_r[l][ACC_W-1:OUT_W-1];
         lane_ovf_s[l] = lane_act_s[l] & ~((&hi_v) | ~(|hi_v));
         if (!lane_ovf_s[l] || !sat_r) begin
            conv_v = acc_r[l][OUT_W-1:0];
         end else if (acc_r[l][ACC_W-1]) begin
            conv_v = {1'b1, {(OUT_W-1){1'b0}}};
         end else begin
            conv_v = {1'b0, {(OUT_W-1){1'b1}}};
         end
         res_next_s[(N-1-sel_v)*OUT_W +: OUT_W] =
            lane_act_s[l] ? conv_v : res_next_s[(N-1-sel_v)*OUT_W +: OUT_W];
      end
   end

   // Job sequencer: accept, N MAC columns per group, write-back, completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= IDLE;
         grp_r     <= '0;
         col_r     <= '0;
         mat_r     <= '0;
         vec_r     <= '0;
         sat_r     <= 1'b0;
         res_r     <= '0;
         ovf_job_r <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         overflow  <= 1'b0;
         vector_c  <= '0;
         for (int l = 0; l < LANES; l++) begin
            acc_r[l] <= '0;
         end
      end else begin
         case (state_r)
            IDLE: begin
               done <= 1'b0;
               if (ena) begin
                  mat_r     <= matrix_a;
                  vec_r     <= vector_b;
                  sat_r     <= sat_mode;
                  grp_r     <= '0;
                  col_r     <= '0;
                  ovf_job_r <= 1'b0;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  state_r   <= MAC;
               end else begin
                  state_r   <= IDLE;
               end
            end
            MAC: begin
               for (int l = 0; l < LANES; l++) begin
                  if (lane_act_s[l]) begin
                     // The first column loads rather than accumulates.
                     if (col_r == COL_W'(0)) begin
                        acc_r[l] <= ACC_W'(prod_s[l]);
                     end else begin
                        acc_r[l] <= acc_r[l] + ACC_W'(prod_s[l]);
                     end
                  end
               end
               if (col_r == COL_LAST) begin
                  state_r <= WRITE;
               end else begin
                  col_r   <= col_r + COL_W'(1);
               end
            end
            WRITE: begin
               res_r     <= res_next_s;
               ovf_job_r <= ovf_job_r | (|lane_ovf_s);
               col_r     <= '0;
               if (grp_r == GRP_LAST) begin
                  // Publish the full buffer, including this group's rows.
                  vector_c <= res_next_s;
                  overflow <= ovf_job_r | (|lane_ovf_s);
                  done     <= 1'b1;
                  in_ready <= 1'b1;
                  busy     <= 1'b0;
                  state_r  <= IDLE;
               end else begin
                  grp_r    <= grp_r + GRP_W'(1);
                  state_r  <= MAC;
               end
            end
            default: begin
               state_r  <= IDLE;
               in_ready <= 1'b1;
               busy     <= 1'b0;
               done     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_vector_multiplier_lanes.sv
// ----------------------------------------------------------------------------
// Bench for matrix_vector_multiplier_lanes. Four instances share the data
// inputs: LANES=1/2/3 with OUT_W=8, and LANES=1 with OUT_W=20. Each has its
// own ena. Expected results are computed by a reference model when a job is
// started and compared when that instance pulses done.
// ----------------------------------------------------------------------------
module tb_matrix_vector_multiplier_lanes;

   localparam logic [71:0] A_SEQ = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
   localparam logic [23:0] B_SEQ = {8'd1, 8'd2, 8'd3};
   localparam logic [71:0] A_MM  = {8'h81, 8'h81, 8'h81, 8'hFF, 8'hFF, 8'h01, 8'h7F, 8'h7F, 8'h7F};
   localparam logic [23:0] B_MM  = {8'h7F, 8'h7F, 8'h7F};
   localparam logic [71:0] A_MIX = {8'd10, 8'hFD, 8'd5, 8'hF8, 8'd12, 8'd0, 8'd7, 8'd1, 8'hFE};
   localparam logic [23:0] B_MIX = {8'hFC, 8'd9, 8'd3};
   localparam logic [71:0] A_ID  = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
   localparam logic [23:0] B_ID  = {8'd2, 8'd7, 8'd99};

   logic        clk = 1'b0;
   logic        rst;
   logic        sat_mode;
   logic [71:0] matrix_a;
   logic [23:0] vector_b;
   logic [3:0]  ena;
   logic [3:0]  in_ready;
   logic [3:0]  done;
   logic [3:0]  busy;
   logic [3:0]  overflow;
   logic [3:0]  done_prev = 4'd0;
   logic [23:0] c0, c1, c2;
   logic [59:0] c3;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int lat_exp [4] = '{12, 8, 4, 12};
   int ow_of   [4] = '{8, 8, 8, 20};

   typedef struct {
      int          id;
      logic [59:0] c;
      logic        ovf;
      int          start;
   } exp_t;
   exp_t sb_q[$];

   matrix_vector_multiplier_lanes #(.N(3), .WIDTH(8), .LANES(1), .OUT_W(8)) u_l1 (
      .clk(clk), .rst(rst), .ena(ena[0]), .in_ready(in_ready[0]), .sat_mode(sat_mode),
      .matrix_a(matrix_a), .vector_b(vector_b), .vector_c(c0), .done(done[0]),
      .busy(busy[0]), .overflow(overflow[0]));
   matrix_vector_multiplier_lanes #(.N(3), .WIDTH(8), .LANES(2), .OUT_W(8)) u_l2 (
      .clk(clk), .rst(rst), .ena(ena[1]), .in_ready(in_ready[1]), .sat_mode(sat_mode),
      .matrix_a(matrix_a), .vector_b(vector_b), .vector_c(c1), .done(done[1]),
      .busy(busy[1]), .overflow(overflow[1]));
   matrix_vector_multiplier_lanes #(.N(3), .WIDTH(8), .LANES(3), .OUT_W(8)) u_l3 (
      .clk(clk), .rst(rst), .ena(ena[2]), .in_ready(in_ready[2]), .sat_mode(sat_mode),
      .matrix_a(matrix_a), .vector_b(vector_b), .vector_c(c2), .done(done[2]),
      .busy(busy[2]), .overflow(overflow[2]));
   matrix_vector_multiplier_lanes #(.N(3), .WIDTH(8), .LANES(1), .OUT_W(20)) u_w20 (
      .clk(clk), .rst(rst), .ena(ena[3]), .in_ready(in_ready[3]), .sat_mode(sat_mode),
      .matrix_a(matrix_a), .vector_b(vector_b), .vector_c(c3), .done(done[3]),
      .busy(busy[3]), .overflow(overflow[3]));

   // Free-running clock and cycle counter.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Reference model: exact integer dot products, then wrap or clamp to ow bits.
   function automatic logic [59:0] model_c(input logic [71:0] ma, input logic [23:0] vb,
                                           input logic sat, input int ow, output logic ovf);
      longint      acc, lo, hi, v;
      logic [59:0] c;
      c   = '0;
      ovf = 1'b0;
      lo  = -(longint'(1) << (ow - 1));
      hi  = (longint'(1) << (ow - 1)) - 1;
      for (int i = 0; i < 3; i++) begin
         acc = 0;
         for (int j = 0; j < 3; j++) begin
            acc += longint'($signed(ma[(8-(i*3+j))*8 +: 8])) * longint'($signed(vb[(2-j)*8 +: 8]));
         end
         v = acc;
         if (acc < lo || acc > hi) begin
            ovf = 1'b1;
            if (sat) v = (acc < 0) ? lo : hi;
         end
         for (int k = 0; k < ow; k++) c[(2-i)*ow + k] = v[k];
      end
      return c;
   endfunction

   function automatic logic [59:0] get_c(input int k);
      case (k)
         0:       return {36'd0, c0};
         1:       return {36'd0, c1};
         2:       return {36'd0, c2};
         default: return c3;
      endcase
   endfunction

   // Drive one ena pulse to the instances in mask; push expectations if accepted.
   task automatic start_job(input logic [3:0] mask, input logic [71:0] ma, input logic [23:0] vb,
                            input logic sat, input bit expect_acc);
      exp_t e;
      logic ovf_e;
      matrix_a = ma;
      vector_b = vb;
      sat_mode = sat;
      for (int k = 0; k < 4; k++) begin
         if (mask[k]) begin
            ena[k] = 1'b1;
            check_val(expect_acc ? "ready_idle" : "ready_busy", 64'(in_ready[k]), 64'(expect_acc));
            if (expect_acc) begin
               e.id    = k;
               e.c     = model_c(ma, vb, sat, ow_of[k], ovf_e);
               e.ovf   = ovf_e;
               e.start = cyc + 1;
               sb_q.push_back(e);
            end
         end
      end
      @(negedge clk);
      ena = ena & ~mask;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_val("sb_drain", 64'(sb_q.size()), 64'd0);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs();
      for (int k = 0; k < 4; k++) begin
         check_val($sformatf("rst_c%0d", k), 64'(get_c(k)), 64'd0);
         check_val($sformatf("rst_ovf%0d", k), 64'(overflow[k]), 64'd0);
         check_val($sformatf("rst_done%0d", k), 64'(done[k]), 64'd0);
         check_val($sformatf("rst_busy%0d", k), 64'(busy[k]), 64'd0);
         check_val($sformatf("rst_ready%0d", k), 64'(in_ready[k]), 64'd1);
      end
   endtask

   task automatic handle_done(input int k);
      int   idx;
      exp_t e;
      idx = -1;
      for (int i = 0; i < sb_q.size(); i++) begin
         if (idx < 0 && sb_q[i].id == k) idx = i;
      end
      check_val($sformatf("done_pulse%0d", k), 64'(done_prev[k]), 64'd0);
      if (idx < 0) begin
         check_val($sformatf("unexpected_done%0d", k), 64'(done[k]), 64'd0);
      end else begin
         e = sb_q[idx];
         sb_q.delete(idx);
         check_val($sformatf("c_dut%0d", k), 64'(get_c(k)), 64'(e.c));
         check_val($sformatf("ovf_dut%0d", k), 64'(overflow[k]), 64'(e.ovf));
         check_val($sformatf("latency_dut%0d", k), 64'(cyc - e.start), 64'(lat_exp[k]));
         check_val($sformatf("busy_done%0d", k), 64'(busy[k]), 64'd0);
         check_val($sformatf("ready_done%0d", k), 64'(in_ready[k]), 64'd1);
      end
   endtask

   // Output monitor: compare each done against the oldest pending job.
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin
            if (done[k]) handle_done(k);
         end
      end
      done_prev <= done;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time=%0t limit=200000", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst      = 1'b1;
      ena      = 4'd0;
      sat_mode = 1'b0;
      matrix_a = '0;
      vector_b = '0;
      repeat (2) @(negedge clk);
      check_reset_outputs();
      rst = 1'b0;
      @(negedge clk);

      // Basic sequence, wrap mode.
      start_job(4'b1001, A_SEQ, B_SEQ, 1'b0, 1'b1);
      wait_idle();
      check_val("seq_fixed", 64'(c0), 64'({8'd14, 8'd32, 8'd50}));

      // Extremes: wrap, then saturate; the OUT_W=20 instance never overflows.
      start_job(4'b1001, A_MM, B_MM, 1'b0, 1'b1);
      wait_idle();
      check_val("mm_wrap_fixed", 64'(c0), 64'(24'hFD8103));
      start_job(4'b1001, A_MM, B_MM, 1'b1, 1'b1);
      wait_idle();
      check_val("mm_sat_fixed", 64'(c0), 64'(24'h80817F));

      // Mixed signs on the 2- and 3-lane builds.
      start_job(4'b0110, A_MIX, B_MIX, 1'b1, 1'b1);
      wait_idle();
      check_val("mix_sat_fixed", 64'(c2), 64'({8'hCC, 8'h7F, 8'hE7}));
      start_job(4'b0110, A_MIX, B_MIX, 1'b0, 1'b1);
      wait_idle();
      check_val("mix_wrap_fixed", 64'(c1), 64'({8'hCC, 8'h8C, 8'hE7}));

      // ena while busy is ignored; ena in the done cycle starts the next job.
      start_job(4'b0001, A_SEQ, B_SEQ, 1'b0, 1'b1);
      start_job(4'b0001, A_MM, B_MM, 1'b1, 1'b0);
      @(negedge clk);
      start_job(4'b0001, A_MIX, B_MIX, 1'b1, 1'b0);
      n = 0;
      while (!done[0] && n < 30) begin
         @(negedge clk);
         n++;
      end
      check_val("done_seen", 64'(done[0]), 64'd1);
      start_job(4'b0001, A_MM, B_MM, 1'b0, 1'b1);
      wait_idle();

      // Asynchronous reset in the middle of a job.
      start_job(4'b1111, A_SEQ, B_SEQ, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check_reset_outputs();
      sb_q.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Fresh job after reset.
      start_job(4'b1111, A_ID, B_ID, 1'b0, 1'b1);
      wait_idle();
      check_val("id_fixed", 64'(c2), 64'(24'h020763));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
